// File: rtl/cdie_pm_clk_rsp.sv
// CDIE-side PM clock-request / DVFS handshake responder on the local half-bridge.
// Optional protocol checker enabled by defining CDIE_PM_CLK_RSP_ERR_CHK_EN.
module cdie_pm_clk_rsp #(
    parameter int unsigned NUM_CLK  = 3,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned ON_DLY   = 16,
    parameter int unsigned OFF_DLY  = 4,
    parameter int unsigned DVFS_DLY = 8
) (
    input  logic               local_half_bridge_clk,
    input  logic               local_half_bridge_rst_b,
    input  logic [NUM_CLK-1:0] clk_req,
    output logic [NUM_CLK-1:0] clk_en,
    output logic [NUM_CLK-1:0] clk_ack,
    input  logic               go_prep_unprep,
    output logic               go_prep_unprep_ack,
    input  logic               go_incgb_decgb_req,
    output logic               go_incgb_decgb_ack,
    output logic               dvfs_busy,
    output logic               err_proto
);

    typedef enum logic [1:0] {CLK_OFF, CLK_RAMP_ON, CLK_ON, CLK_RAMP_OFF} clk_st_e;
    typedef enum logic {DV_IDLE, DV_WAIT} dv_st_e;

    localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(ON_DLY - 1);
    localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(OFF_DLY - 1);
    localparam logic [CNT_W-1:0] DV_LD  = CNT_W'(DVFS_DLY - 1);

    logic [NUM_CLK-1:0] r_req_m, r_req_s;
    logic               r_prep_m, r_prep_s;
    logic               r_inc_m, r_inc_s;

    always_ff @(posedge local_half_bridge_clk or negedge local_half_bridge_rst_b) begin
        if (!local_half_bridge_rst_b) begin
            r_req_m  <= '0;
            r_req_s  <= '0;
            r_prep_m <= 1'b0;
            r_prep_s <= 1'b0;
            r_inc_m  <= 1'b0;
            r_inc_s  <= 1'b0;
        end else begin
            r_req_m  <= clk_req;
            r_req_s  <= r_req_m;
            r_prep_m <= go_prep_unprep;
            r_prep_s <= r_prep_m;
            r_inc_m  <= go_incgb_decgb_req;
            r_inc_s  <= r_inc_m;
        end
    end

`ifdef CDIE_PM_CLK_RSP_ERR_CHK_EN
    logic [NUM_CLK-1:0] w_ramp_abort;
`endif

    for (genvar g = 0; g < NUM_CLK; g++) begin : g_src
        clk_st_e          r_st;
        logic [CNT_W-1:0] r_cnt;
        logic             r_en;
        logic             r_ack;

        always_ff @(posedge local_half_bridge_clk or negedge local_half_bridge_rst_b) begin
            if (!local_half_bridge_rst_b) begin
                r_st  <= CLK_OFF;
                r_cnt <= '0;
                r_en  <= 1'b0;
                r_ack <= 1'b0;
            end else begin
                case (r_st)
                    CLK_OFF: begin
                        if (r_req_s[g]) begin
                            r_st  <= CLK_RAMP_ON;
                            r_cnt <= ON_LD;
                            r_en  <= 1'b1;
                        end
                    end
                    CLK_RAMP_ON: begin
                        if (!r_req_s[g]) begin
                            r_st  <= CLK_RAMP_OFF;
                            r_cnt <= OFF_LD;
                            r_en  <= 1'b0;
                        end else if (r_cnt == '0) begin
                            r_st  <= CLK_ON;
                            r_ack <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    CLK_ON: begin
                        if (!r_req_s[g]) begin
                            r_st  <= CLK_RAMP_OFF;
                            r_cnt <= OFF_LD;
                            r_en  <= 1'b0;
                        end
                    end
                    CLK_RAMP_OFF: begin
                        // ack keeps its entry value until the off ramp completes
                        if (r_cnt == '0) begin
                            r_st  <= CLK_OFF;
                            r_ack <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        r_st  <= CLK_OFF;
                        r_en  <= 1'b0;
                        r_ack <= 1'b0;
                    end
                endcase
            end
        end

        assign clk_en[g]  = r_en;
        assign clk_ack[g] = r_ack;
`ifdef CDIE_PM_CLK_RSP_ERR_CHK_EN
        assign w_ramp_abort[g] = (r_st == CLK_RAMP_ON) && !r_req_s[g];
`endif
    end

    dv_st_e           r_prep_st;
    logic [CNT_W-1:0] r_prep_cnt;
    logic             r_prep_ack;
    logic             w_prep_done;
    logic             w_prep_ack_nxt;

    assign w_prep_done    = (r_prep_st == DV_WAIT) && (r_prep_s != r_prep_ack) && (r_prep_cnt == '0);
    assign w_prep_ack_nxt = w_prep_done ? r_prep_s : r_prep_ack;

    always_ff @(posedge local_half_bridge_clk or negedge local_half_bridge_rst_b) begin
        if (!local_half_bridge_rst_b) begin
            r_prep_st  <= DV_IDLE;
            r_prep_cnt <= '0;
            r_prep_ack <= 1'b0;
        end else begin
            case (r_prep_st)
                DV_IDLE: begin
                    if (r_prep_s != r_prep_ack) begin
                        r_prep_st  <= DV_WAIT;
                        r_prep_cnt <= DV_LD;
                    end
                end
                DV_WAIT: begin
                    if (r_prep_s == r_prep_ack) begin
                        r_prep_st <= DV_IDLE;
                    end else if (r_prep_cnt == '0) begin
                        r_prep_st  <= DV_IDLE;
                        r_prep_ack <= r_prep_s;
                    end else begin
                        r_prep_cnt <= r_prep_cnt - CNT_W'(1);
                    end
                end
                default: r_prep_st <= DV_IDLE;
            endcase
        end
    end

    // Rising incgb ack needs prep ack; using its next value lets the count start on the prep-ack edge
    dv_st_e           r_inc_st;
    logic [CNT_W-1:0] r_inc_cnt;
    logic             r_inc_ack;
    logic             w_inc_ok;

    assign w_inc_ok = !r_inc_s || w_prep_ack_nxt;

    always_ff @(posedge local_half_bridge_clk or negedge local_half_bridge_rst_b) begin
        if (!local_half_bridge_rst_b) begin
            r_inc_st  <= DV_IDLE;
            r_inc_cnt <= '0;
            r_inc_ack <= 1'b0;
        end else begin
            case (r_inc_st)
                DV_IDLE: begin
                    if ((r_inc_s != r_inc_ack) && w_inc_ok) begin
                        r_inc_st  <= DV_WAIT;
                        r_inc_cnt <= DV_LD;
                    end
                end
                DV_WAIT: begin
                    if ((r_inc_s == r_inc_ack) || !w_inc_ok) begin
                        r_inc_st <= DV_IDLE;
                    end else if (r_inc_cnt == '0) begin
                        r_inc_st  <= DV_IDLE;
                        r_inc_ack <= r_inc_s;
                    end else begin
                        r_inc_cnt <= r_inc_cnt - CNT_W'(1);
                    end
                end
                default: r_inc_st <= DV_IDLE;
            endcase
        end
    end

    assign go_prep_unprep_ack = r_prep_ack;
    assign go_incgb_decgb_ack = r_inc_ack;
    assign dvfs_busy          = (r_prep_st == DV_WAIT) || (r_inc_st == DV_WAIT);

`ifdef CDIE_PM_CLK_RSP_ERR_CHK_EN
    logic r_inc_s_d;
    logic r_err;

    always_ff @(posedge local_half_bridge_clk or negedge local_half_bridge_rst_b) begin
        if (!local_half_bridge_rst_b) begin
            r_inc_s_d <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_inc_s_d <= r_inc_s;
            if ((|w_ramp_abort) || (r_inc_s && !r_inc_s_d && !r_prep_ack))
                r_err <= 1'b1;
        end
    end

    assign err_proto = r_err;
`else
    assign err_proto = 1'b0;
`endif

endmodule

// File: tb/tb_cdie_pm_clk_rsp.sv
// Scoreboard bench for cdie_pm_clk_rsp: expected output transitions are queued by the
// stimulus and matched, by cycle and value, against every observed output change.
module tb_cdie_pm_clk_rsp;

`ifdef CDIE_PM_CLK_RSP_ERR_CHK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_b;
    logic [2:0] clk_req;
    logic [2:0] clk_en;
    logic [2:0] clk_ack;
    logic       prep;
    logic       prep_ack;
    logic       inc;
    logic       inc_ack;
    logic       busy;
    logic       err;
    logic [8:0] w_obs;

    // bits: [8]=busy [7]=incgb ack [6]=prep ack [5:3]=clk_ack [2:0]=clk_en
    assign w_obs = {busy, inc_ack, prep_ack, clk_ack, clk_en};

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic       mon_en = 1'b0;
    logic [8:0] prev   = '0;

    typedef struct {
        int         cyc;
        logic [8:0] v;
        string      nm;
    } ev_t;
    ev_t q[$];

    cdie_pm_clk_rsp #(
        .NUM_CLK (3),
        .CNT_W   (8),
        .ON_DLY  (16),
        .OFF_DLY (4),
        .DVFS_DLY(8)
    ) dut (
        .local_half_bridge_clk  (clk),
        .local_half_bridge_rst_b(rst_b),
        .clk_req                (clk_req),
        .clk_en                 (clk_en),
        .clk_ack                (clk_ack),
        .go_prep_unprep         (prep),
        .go_prep_unprep_ack     (prep_ack),
        .go_incgb_decgb_req     (inc),
        .go_incgb_decgb_ack     (inc_ack),
        .dvfs_busy              (busy),
        .err_proto              (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expv(input int c, input logic [8:0] v, input string nm);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_en && (w_obs !== prev)) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change got=%h prev=%h at cyc %0d", w_obs, prev, cyc);
                end else begin
                    e = q.pop_front();
                    if ((e.cyc != cyc) || (e.v !== w_obs)) begin
                        bad++;
                        $display("FAIL %s got=%h@%0d exp=%h@%0d", e.nm, w_obs, cyc, e.v, e.cyc);
                    end
                end
            end
            prev = w_obs;
        end
    endtask

    initial begin
        int t;
        fork
            monitor();
        join_none

        rst_b   = 1'b0;
        clk_req = '0;
        prep    = 1'b0;
        inc     = 1'b0;
        step(3);
        check("reset_outputs", w_obs, '0);
        check("reset_err", {8'd0, err}, '0);
        rst_b  = 1'b1;
        mon_en = 1'b1;
        step(100);
        check("idle_100", w_obs, '0);

        // bclk on then off
        t = cyc; clk_req[0] = 1'b1;
        expv(t + 3, 9'h001, "bclk_en_rise");
        expv(t + 19, 9'h009, "bclk_ack_rise");
        step(25);
        t = cyc; clk_req[0] = 1'b0;
        expv(t + 3, 9'h008, "bclk_en_fall");
        expv(t + 7, 9'h000, "bclk_ack_fall");
        step(12);

        // xtal 5-cycle pulse aborts the on ramp
        t = cyc; clk_req[1] = 1'b1;
        expv(t + 3, 9'h002, "xtal_en_rise");
        expv(t + 8, 9'h000, "xtal_en_fall");
        step(5);
        clk_req[1] = 1'b0;
        step(12);
        check("err_after_abort", {8'd0, err}, {8'd0, ERR_ON});

        // all three together, then drop cro alone
        t = cyc; clk_req = 3'b111;
        expv(t + 3, 9'h007, "all_en_rise");
        expv(t + 19, 9'h03F, "all_ack_rise");
        step(25);
        t = cyc; clk_req[2] = 1'b0;
        expv(t + 3, 9'h03B, "cro_en_fall");
        expv(t + 7, 9'h01B, "cro_ack_fall");
        step(12);
        t = cyc; clk_req = 3'b000;
        expv(t + 3, 9'h018, "rest_en_fall");
        expv(t + 7, 9'h000, "rest_ack_fall");
        step(12);

        // re-request while ramping off: finish the ramp, then restart
        t = cyc; clk_req[0] = 1'b1;
        expv(t + 3, 9'h001, "rr_en_rise");
        expv(t + 19, 9'h009, "rr_ack_rise");
        step(25);
        t = cyc; clk_req[0] = 1'b0;
        expv(t + 3, 9'h008, "rr_en_fall");
        expv(t + 7, 9'h000, "rr_ack_fall");
        expv(t + 8, 9'h001, "rr_en_again");
        expv(t + 24, 9'h009, "rr_ack_again");
        step(2);
        clk_req[0] = 1'b1;
        step(28);
        t = cyc; clk_req[0] = 1'b0;
        expv(t + 3, 9'h008, "rr2_en_fall");
        expv(t + 7, 9'h000, "rr2_ack_fall");
        step(12);

        // incgb held until prep ack rises
        inc = 1'b1;
        step(20);
        check("incgb_held", w_obs, '0);
        check("err_after_incgb", {8'd0, err}, {8'd0, ERR_ON});
        t = cyc; prep = 1'b1;
        expv(t + 3, 9'h100, "prep_busy");
        expv(t + 11, 9'h140, "prep_ack_rise");
        expv(t + 19, 9'h0C0, "incgb_ack_rise");
        step(25);
        t = cyc; inc = 1'b0;
        expv(t + 3, 9'h1C0, "incgb_fall_busy");
        expv(t + 11, 9'h040, "incgb_ack_fall");
        step(15);
        t = cyc; prep = 1'b0;
        expv(t + 3, 9'h140, "unprep_busy");
        expv(t + 11, 9'h000, "prep_ack_fall");
        step(15);

        // DVFS request reverts mid-count
        t = cyc; prep = 1'b1;
        expv(t + 3, 9'h100, "abort_busy");
        expv(t + 6, 9'h000, "abort_idle");
        step(3);
        prep = 1'b0;
        step(15);

        // reset during RAMP_ON and DVFS WAIT, requests stay high across it
        t = cyc; clk_req[0] = 1'b1; prep = 1'b1;
        expv(t + 3, 9'h101, "pre_rst_start");
        expv(t + 6, 9'h000, "async_reset_drop");
        step(6);
        #1 rst_b = 1'b0;
        #1 check("async_reset_now", w_obs, '0);
        check("async_reset_err", {8'd0, err}, '0);
        step(3);
        rst_b = 1'b1;
        t = cyc;
        expv(t + 3, 9'h101, "post_rst_start");
        expv(t + 11, 9'h041, "post_rst_prep_ack");
        expv(t + 19, 9'h049, "post_rst_bclk_ack");
        step(25);
        t = cyc; clk_req[0] = 1'b0; prep = 1'b0;
        expv(t + 3, 9'h148, "final_en_fall");
        expv(t + 7, 9'h140, "final_ack_fall");
        expv(t + 11, 9'h000, "final_prep_fall");
        step(16);
        check("final_err", {8'd0, err}, '0);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL events_left got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
